// File: rtl/branch_resolution_unit_if.sv
`default_nettype none
// ============================================================================
// branch_resolution_unit_if
// Fetch push, execute resolve and predictor update signals of the BRU.
// Revision: 1.0
// ============================================================================
interface branch_resolution_unit_if #(
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 32
);
  logic                  push_valid_f;
  logic [PC_WIDTH-1:0]   push_pc_f;
  logic                  push_pred_taken_f;
  logic [PC_WIDTH-1:0]   push_pred_target_f;
  logic                  queue_full_o;
  logic                  ex_valid_e;
  logic                  ex_taken_e;
  logic [PC_WIDTH-1:0]   ex_target_e;
  logic                  branch_resolved_o;
  logic                  actual_taken_o;
  logic [PC_WIDTH-1:0]   branch_pc_o;
  logic                  branch_mispredict_o;
  logic                  redirect_valid_o;
  logic [PC_WIDTH-1:0]   redirect_pc_o;
  logic [STAT_WIDTH-1:0] branch_count_o;
  logic [STAT_WIDTH-1:0] mispredict_count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output push_valid_f, push_pc_f, push_pred_taken_f, push_pred_target_f,
    output ex_valid_e, ex_taken_e, ex_target_e,
    input  queue_full_o, branch_resolved_o, actual_taken_o, branch_pc_o,
    input  branch_mispredict_o, redirect_valid_o, redirect_pc_o,
    input  branch_count_o, mispredict_count_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_valid_f, push_pc_f, push_pred_taken_f, push_pred_target_f,
    input  ex_valid_e, ex_taken_e, ex_target_e,
    output queue_full_o, branch_resolved_o, actual_taken_o, branch_pc_o,
    output branch_mispredict_o, redirect_valid_o, redirect_pc_o,
    output branch_count_o, mispredict_count_o, overflow_o, underflow_o
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolution_unit.sv
`default_nettype none
// ============================================================================
// branch_resolution_unit
// In-flight prediction FIFO, resolve/mispredict pulses, redirect and stats.
// Revision: 1.0
// ============================================================================
module branch_resolution_unit #(
  parameter int QUEUE_DEPTH = 4,
  parameter int PC_WIDTH    = 32,
  parameter int STAT_WIDTH  = 32
) (
  input  wire logic clk,
  input  wire logic rst_n,
  branch_resolution_unit_if.slave bus
);
  localparam int                c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(QUEUE_DEPTH);

  logic [PC_WIDTH-1:0]   r_pc_mem    [QUEUE_DEPTH];
  logic                  r_taken_mem [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]   r_tgt_mem   [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W:0]      r_count;

  logic                  r_resolved;
  logic                  r_actual_taken;
  logic [PC_WIDTH-1:0]   r_branch_pc;
  logic                  r_mispredict;
  logic                  r_redirect;
  logic [PC_WIDTH-1:0]   r_redirect_pc;
  logic [STAT_WIDTH-1:0] r_branch_cnt;
  logic [STAT_WIDTH-1:0] r_mispredict_cnt;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_mispredict;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_drop;
  logic [PC_WIDTH-1:0]   w_head_pc;
  logic                  w_head_taken;
  logic [PC_WIDTH-1:0]   w_head_tgt;
  logic [PC_WIDTH-1:0]   w_correct_pc;

  assign w_full       = (r_count == c_DEPTH);
  assign w_empty      = (r_count == '0);
  assign w_pop        = bus.ex_valid_e && !w_empty;
  assign w_head_pc    = r_pc_mem[r_rd_ptr];
  assign w_head_taken = r_taken_mem[r_rd_ptr];
  assign w_head_tgt   = r_tgt_mem[r_rd_ptr];

  // Target only matters when both prediction and outcome say taken.
  assign w_mispredict = w_pop &&
                        ((w_head_taken != bus.ex_taken_e) ||
                         (w_head_taken && bus.ex_taken_e && (w_head_tgt != bus.ex_target_e)));
  assign w_correct_pc = bus.ex_taken_e ? bus.ex_target_e : (w_head_pc + PC_WIDTH'(4));

  // Fetch is on the wrong path during the mispredict and redirect cycles.
  assign w_push_req = bus.push_valid_f && !r_redirect && !w_mispredict;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= bus.push_pc_f;
      r_taken_mem[r_wr_ptr] <= bus.push_pred_taken_f;
      r_tgt_mem[r_wr_ptr]   <= bus.push_pred_target_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_mispredict) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resolved       <= 1'b0;
      r_actual_taken   <= 1'b0;
      r_branch_pc      <= '0;
      r_mispredict     <= 1'b0;
      r_redirect       <= 1'b0;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
      r_overflow       <= 1'b0;
      r_underflow      <= 1'b0;
    end else begin
      r_resolved   <= w_pop;
      r_mispredict <= w_mispredict;
      r_redirect   <= w_mispredict;
      if (w_pop) begin
        r_actual_taken <= bus.ex_taken_e;
        r_branch_pc    <= w_head_pc;
        r_redirect_pc  <= w_correct_pc;
        if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_mispredict && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      if (bus.ex_valid_e && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.queue_full_o        = w_full;
  assign bus.branch_resolved_o   = r_resolved;
  assign bus.actual_taken_o      = r_actual_taken;
  assign bus.branch_pc_o         = r_branch_pc;
  assign bus.branch_mispredict_o = r_mispredict;
  assign bus.redirect_valid_o    = r_redirect;
  assign bus.redirect_pc_o       = r_redirect_pc;
  assign bus.branch_count_o      = r_branch_cnt;
  assign bus.mispredict_count_o  = r_mispredict_cnt;
  assign bus.overflow_o          = r_overflow;
  assign bus.underflow_o         = r_underflow;
endmodule
`default_nettype wire
